fg_sweep_controller: RTL and testbench

//  Sequences the DDS datapath (phase accumulator + waveform ROM) through a frequency sweep.

---
 rtl/fg_sweep_controller_if.sv | 37 +++
 rtl/fg_sweep_controller.sv | 216 +++++++++++++++++++++
 tb/tb_fg_sweep_controller.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fg_sweep_controller_if.sv
// rtl/fg_sweep_controller_if.sv - sweep configuration handshake bundle
//
// Purpose: carries one sweep configuration from the control source to
//          fg_sweep_controller with a valid/ready handshake.
// Signals:
//   cfg_valid  master->slave  configuration offered
//   cfg_ready  slave->master  configuration taken when valid & ready
//   cfg_start  master->slave  first step value
//   cfg_stop   master->slave  last allowed step value
//   cfg_inc    master->slave  step increment between points
//   cfg_dwell  master->slave  each point held for cfg_dwell+1 ticks
//   cfg_wave   master->slave  waveform for the whole sweep
//   cfg_loops  master->slave  sweep repetitions, 0 = until abort
interface fg_sweep_controller_if #(
   parameter int STEP_W  = 8,
   parameter int DWELL_W = 16,
   parameter int LOOP_W  = 8
);
   logic               cfg_valid;
   logic               cfg_ready;
   logic [STEP_W-1:0]  cfg_start;
   logic [STEP_W-1:0]  cfg_stop;
   logic [STEP_W-1:0]  cfg_inc;
   logic [DWELL_W-1:0] cfg_dwell;
   logic [1:0]         cfg_wave;
   logic [LOOP_W-1:0]  cfg_loops;

   modport master (
      output cfg_valid, cfg_start, cfg_stop, cfg_inc, cfg_dwell, cfg_wave, cfg_loops,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_start, cfg_stop, cfg_inc, cfg_dwell, cfg_wave, cfg_loops,
      output cfg_ready
   );
endinterface

// File: rtl/fg_sweep_controller.sv
// rtl/fg_sweep_controller.sv - DDS frequency sweep sequencer
//
// Purpose: steps the phase-accumulator increment (f_step) through a
//          configured frequency sweep, holding each point for a number of
//          sample ticks, and drives wave_select / phase_en for the ROM.
// Optional feature: define FG_SWEEP_PINGPONG_EN for up-then-down sweeps;
//          undefined gives sawtooth (up-only) sweeps.
// Ports:
//   clk_50MHz_i    system clock, all logic on posedge
//   rst_i          synchronous active-high reset
//   tick_i         1-cycle sample strobe; dwell counts only on tick
//   cfg            configuration handshake (slave modport)
//   start_i        begin sweep (level, sampled each cycle)
//   abort_i        stop immediately
//   f_step_o       step to the phase accumulator
//   wave_select_o  ROM waveform select
//   phase_en_o     enables phase accumulator and ROM
//   busy_o         high while sweeping
//   done_o         1-cycle pulse at normal sweep completion
//   cfg_err_o      1-cycle pulse when an offered config is rejected
module fg_sweep_controller #(
   parameter int STEP_W  = 8,
   parameter int DWELL_W = 16,
   parameter int LOOP_W  = 8
) (
   input  logic                clk_50MHz_i,
   input  logic                rst_i,
   input  logic                tick_i,
   fg_sweep_controller_if.slave cfg,
   input  logic                start_i,
   input  logic                abort_i,
   output logic [STEP_W-1:0]   f_step_o,
   output logic [1:0]          wave_select_o,
   output logic                phase_en_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                cfg_err_o
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

   state_t             state_q;

   // latched configuration
   logic [STEP_W-1:0]  start_q, stop_q, inc_q;
   logic [DWELL_W-1:0] dwell_cfg_q;
   logic [1:0]         wave_cfg_q;
   logic [LOOP_W-1:0]  loops_cfg_q;

   // run-time counters and registered outputs
   logic [DWELL_W-1:0] dwell_q;
   logic [LOOP_W-1:0]  loop_q;
   logic [STEP_W-1:0]  f_step_q;
   logic [1:0]         wave_q;
   logic               phase_en_q, busy_q, done_q, cfg_err_q, cfg_ready_q;

   logic               accept_d, cfg_ok_d, loop_end_d;
   logic [STEP_W:0]    nxt_up_d;
   logic [STEP_W-1:0]  adv_step_d;

`ifdef FG_SWEEP_PINGPONG_EN
   logic               dir_down_q, dir_down_d, dn_under_d;
   logic [STEP_W:0]    nxt_dn_d;

   assign nxt_dn_d   = {1'b0, f_step_q} - {1'b0, inc_q};
   // one extra bit so an underflow past zero reads as negative
   assign dn_under_d = $signed(nxt_dn_d) < $signed({1'b0, start_q});
`endif

   // abort outranks a config offer in the same cycle
   assign accept_d = cfg.cfg_valid & cfg_ready_q & ~abort_i;
   assign cfg_ok_d = (cfg.cfg_inc != '0) && (cfg.cfg_start <= cfg.cfg_stop);
   // one extra bit so f_step+inc never wraps past the top of the range
   assign nxt_up_d = {1'b0, f_step_q} + {1'b0, inc_q};

   // next point of the current loop, or loop_end_d when the loop is used up
   always_comb begin
      loop_end_d = 1'b0;
      adv_step_d = f_step_q;
`ifdef FG_SWEEP_PINGPONG_EN
      dir_down_d = dir_down_q;
      if (!dir_down_q) begin
         if (nxt_up_d <= {1'b0, stop_q}) begin
            adv_step_d = nxt_up_d[STEP_W-1:0];
         end else if (dn_under_d) begin
            loop_end_d = 1'b1;
         end else begin
            // turn at the top without repeating the top point
            adv_step_d = nxt_dn_d[STEP_W-1:0];
            dir_down_d = 1'b1;
         end
      end else if (dn_under_d) begin
         loop_end_d = 1'b1;
      end else begin
         adv_step_d = nxt_dn_d[STEP_W-1:0];
      end
`else
      if (nxt_up_d <= {1'b0, stop_q}) begin
         adv_step_d = nxt_up_d[STEP_W-1:0];
      end else begin
         loop_end_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk_50MHz_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         start_q     <= '0;
         stop_q      <= '0;
         inc_q       <= '0;
         dwell_cfg_q <= '0;
         wave_cfg_q  <= '0;
         loops_cfg_q <= '0;
         dwell_q     <= '0;
         loop_q      <= '0;
         f_step_q    <= '0;
         wave_q      <= '0;
         phase_en_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
         cfg_ready_q <= 1'b1;
`ifdef FG_SWEEP_PINGPONG_EN
         dir_down_q  <= 1'b0;
`endif
      end else begin
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         if (abort_i) begin
            // only IDLE lacks a held config; every other state falls back to ARMED
            state_q     <= (state_q == S_IDLE) ? S_IDLE : S_ARMED;
            f_step_q    <= '0;
            phase_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
`ifdef FG_SWEEP_PINGPONG_EN
            dir_down_q  <= 1'b0;
`endif
         end else begin
            unique case (state_q)
               S_IDLE, S_ARMED: begin
                  if (accept_d) begin
                     // a rejected config leaves any held config untouched
                     if (cfg_ok_d) begin
                        start_q     <= cfg.cfg_start;
                        stop_q      <= cfg.cfg_stop;
                        inc_q       <= cfg.cfg_inc;
                        dwell_cfg_q <= cfg.cfg_dwell;
                        wave_cfg_q  <= cfg.cfg_wave;
                        loops_cfg_q <= cfg.cfg_loops;
                        state_q     <= S_ARMED;
                     end else begin
                        cfg_err_q   <= 1'b1;
                     end
                  end else if (state_q == S_ARMED && start_i) begin
                     state_q     <= S_RUN;
                     f_step_q    <= start_q;
                     wave_q      <= wave_cfg_q;
                     phase_en_q  <= 1'b1;
                     busy_q      <= 1'b1;
                     dwell_q     <= dwell_cfg_q;
                     loop_q      <= loops_cfg_q;
                     cfg_ready_q <= 1'b0;
`ifdef FG_SWEEP_PINGPONG_EN
                     dir_down_q  <= 1'b0;
`endif
                  end
               end
               S_RUN: begin
                  if (tick_i) begin
                     if (dwell_q != '0) begin
                        dwell_q <= dwell_q - 1'b1;
                     end else begin
                        dwell_q <= dwell_cfg_q;
                        if (!loop_end_d) begin
                           f_step_q   <= adv_step_d;
`ifdef FG_SWEEP_PINGPONG_EN
                           dir_down_q <= dir_down_d;
`endif
                        end else if (loop_q == LOOP_W'(1)) begin
                           state_q    <= S_DONE;
                           done_q     <= 1'b1;
                           phase_en_q <= 1'b0;
                           busy_q     <= 1'b0;
                           f_step_q   <= '0;
                        end else begin
                           // loop_q==0 means run forever, so it is never decremented
                           f_step_q   <= start_q;
                           if (loop_q != '0) loop_q <= loop_q - 1'b1;
`ifdef FG_SWEEP_PINGPONG_EN
                           dir_down_q <= 1'b0;
`endif
                        end
                     end
                  end
               end
               S_DONE: begin
                  state_q     <= S_ARMED;
                  cfg_ready_q <= 1'b1;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign cfg.cfg_ready   = cfg_ready_q;
   assign f_step_o        = f_step_q;
   assign wave_select_o   = wave_q;
   assign phase_en_o      = phase_en_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign cfg_err_o       = cfg_err_q;

endmodule

// File: tb/tb_fg_sweep_controller.sv
// tb/tb_fg_sweep_controller.sv - self-checking bench for fg_sweep_controller
module tb_fg_sweep_controller;
   localparam int STEP_W  = 8;
   localparam int DWELL_W = 16;
   localparam int LOOP_W  = 8;

   logic              clk = 1'b0;
   logic              rst, tick, start, abort;
   logic [STEP_W-1:0] f_step;
   logic [1:0]        wave_select;
   logic              phase_en, busy, done, cfg_err;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_q[$];

   fg_sweep_controller_if #(.STEP_W(STEP_W), .DWELL_W(DWELL_W), .LOOP_W(LOOP_W)) cfg_bus ();

   fg_sweep_controller #(.STEP_W(STEP_W), .DWELL_W(DWELL_W), .LOOP_W(LOOP_W)) dut (
      .clk_50MHz_i   (clk),
      .rst_i         (rst),
      .tick_i        (tick),
      .cfg           (cfg_bus),
      .start_i       (start),
      .abort_i       (abort),
      .f_step_o      (f_step),
      .wave_select_o (wave_select),
      .phase_en_o    (phase_en),
      .busy_o        (busy),
      .done_o        (done),
      .cfg_err_o     (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // expected f_step for every tick slot of a whole sweep, built from the point list
   function automatic void build_seq(input int s, input int e, input int inc, input int dw, input int loops);
      int pts[$];
      int p;
      exp_q.delete();
      p = s;
      while (p <= e) begin
         pts.push_back(p);
         p = p + inc;
      end
`ifdef FG_SWEEP_PINGPONG_EN
      p = pts[pts.size()-1] - inc;
      while (p >= s) begin
         pts.push_back(p);
         p = p - inc;
      end
`endif
      for (int l = 0; l < loops; l++)
         foreach (pts[k])
            for (int d = 0; d <= dw; d++)
               exp_q.push_back(pts[k]);
   endfunction

   task automatic load_cfg(input int s, input int e, input int inc, input int dw, input int w, input int loops);
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_start = STEP_W'(s);
      cfg_bus.cfg_stop  = STEP_W'(e);
      cfg_bus.cfg_inc   = STEP_W'(inc);
      cfg_bus.cfg_dwell = DWELL_W'(dw);
      cfg_bus.cfg_wave  = 2'(w);
      cfg_bus.cfg_loops = LOOP_W'(loops);
      cyc();
      cfg_bus.cfg_valid = 1'b0;
   endtask

   // tick_mode 0: tick every 4th cycle, 1: random ticks.
   // abort_after >= 0 aborts once that many ticks were consumed.
   task automatic run_sweep(input int s, input int e, input int inc, input int dw, input int w,
                            input int loops, input int tick_mode, input int abort_after, input bit hold_start);
      int idx, cnt;
      bit was;
      build_seq(s, e, inc, dw, (loops == 0) ? 3 : loops);
      load_cfg(s, e, inc, dw, w, loops);
      n_tests++;
      if (cfg_err !== 1'b0) begin
         n_fail++; $display("FAIL cfg_accept: cfg_err=%0b want 0", cfg_err);
      end
      start = 1'b1;
      cyc();
      if (!hold_start) start = 1'b0;
      n_tests++;
      if (busy !== 1'b1 || phase_en !== 1'b1 || f_step !== STEP_W'(exp_q[0]) || wave_select !== 2'(w)) begin
         n_fail++;
         $display("FAIL run_entry: busy=%0b en=%0b f_step=%0d wave=%0d want 1 1 %0d %0d",
                  busy, phase_en, f_step, wave_select, exp_q[0], w);
      end
      idx = 0;
      cnt = 0;
      forever begin
         if (abort_after >= 0 && idx == abort_after) break;
         tick = (tick_mode == 0) ? ((cnt % 4) == 3) : 1'($urandom_range(0, 1));
         cnt++;
         cyc();
         was = tick;
         tick = 1'b0;
         if (cnt > 20000) begin
            n_tests++; n_fail++;
            $display("FAIL sweep_timeout: idx=%0d want %0d", idx, exp_q.size());
            break;
         end
         if (was) idx++;
         n_tests++;
         if (idx >= exp_q.size()) begin
            if (done !== 1'b1 || phase_en !== 1'b0 || busy !== 1'b0 || f_step !== '0) begin
               n_fail++;
               $display("FAIL done_cycle: done=%0b en=%0b busy=%0b f_step=%0d want 1 0 0 0",
                        done, phase_en, busy, f_step);
            end
            cyc();
            n_tests++;
            if (done !== 1'b0 || cfg_bus.cfg_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL after_done: done=%0b ready=%0b want 0 1", done, cfg_bus.cfg_ready);
            end
            return;
         end
         if (f_step !== STEP_W'(exp_q[idx]) || done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_point: slot=%0d f_step=%0d done=%0b busy=%0b want %0d 0 1",
                     idx, f_step, done, busy, exp_q[idx]);
         end
      end
      // abort together with a tick (and possibly a held start)
      abort = 1'b1;
      tick = 1'b1;
      cyc();
      abort = 1'b0;
      tick = 1'b0;
      n_tests++;
      if (phase_en !== 1'b0 || busy !== 1'b0 || f_step !== '0 || done !== 1'b0 || cfg_bus.cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL abort: en=%0b busy=%0b f_step=%0d done=%0b ready=%0b want 0 0 0 0 1",
                  phase_en, busy, f_step, done, cfg_bus.cfg_ready);
      end
      if (hold_start) begin
         cyc();
         start = 1'b0;
         n_tests++;
         if (busy !== 1'b1 || f_step !== STEP_W'(s)) begin
            n_fail++;
            $display("FAIL relaunch: busy=%0b f_step=%0d want 1 %0d", busy, f_step, s);
         end
         abort = 1'b1;
         cyc();
         abort = 1'b0;
         n_tests++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL relaunch_abort: busy=%0b done=%0b want 0 0", busy, done);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc();
      cyc();
      n_tests++;
      if (f_step !== '0 || wave_select !== '0 || phase_en !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || cfg_err !== 1'b0 || cfg_bus.cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset: f=%0d w=%0d en=%0b busy=%0b done=%0b err=%0b ready=%0b want 0 0 0 0 0 0 1",
                  f_step, wave_select, phase_en, busy, done, cfg_err, cfg_bus.cfg_ready);
      end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_bad_cfg();
      load_cfg(10, 5, 1, 0, 0, 1);
      n_tests++;
      if (cfg_err !== 1'b1 || cfg_bus.cfg_ready !== 1'b1) begin
         n_fail++; $display("FAIL bad_cfg_order: err=%0b ready=%0b want 1 1", cfg_err, cfg_bus.cfg_ready);
      end
      cyc();
      n_tests++;
      if (cfg_err !== 1'b0) begin
         n_fail++; $display("FAIL bad_cfg_pulse: err=%0b want 0", cfg_err);
      end
      load_cfg(5, 10, 0, 0, 0, 1);
      n_tests++;
      if (cfg_err !== 1'b1) begin
         n_fail++; $display("FAIL bad_cfg_inc0: err=%0b want 1", cfg_err);
      end
      start = 1'b1;
      cyc();
      start = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || phase_en !== 1'b0) begin
         n_fail++; $display("FAIL bad_cfg_idle: busy=%0b en=%0b want 0 0", busy, phase_en);
      end
   endtask

   task automatic test_armed_replace();
      load_cfg(50, 60, 5, 1, 2, 1);
      load_cfg(20, 10, 1, 0, 0, 1);
      n_tests++;
      if (cfg_err !== 1'b1) begin
         n_fail++; $display("FAIL replace_bad: err=%0b want 1", cfg_err);
      end
      start = 1'b1;
      cyc();
      start = 1'b0;
      n_tests++;
      if (busy !== 1'b1 || f_step !== 8'd50 || wave_select !== 2'd2) begin
         n_fail++; $display("FAIL replace_keep: busy=%0b f=%0d w=%0d want 1 50 2", busy, f_step, wave_select);
      end
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      // config offer and start together: config taken, start ignored
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_start = 8'd70;
      cfg_bus.cfg_stop  = 8'd90;
      cfg_bus.cfg_inc   = 8'd3;
      start = 1'b1;
      cyc();
      cfg_bus.cfg_valid = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || cfg_err !== 1'b0) begin
         n_fail++; $display("FAIL cfg_start_same: busy=%0b err=%0b want 0 0", busy, cfg_err);
      end
      cyc();
      start = 1'b0;
      n_tests++;
      if (busy !== 1'b1 || f_step !== 8'd70) begin
         n_fail++; $display("FAIL cfg_start_next: busy=%0b f=%0d want 1 70", busy, f_step);
      end
      abort = 1'b1;
      cyc();
      abort = 1'b0;
   endtask

   task automatic test_rst_mid_run();
      load_cfg(30, 90, 7, 0, 1, 0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      n_tests++;
      if (f_step !== '0 || wave_select !== '0 || phase_en !== 1'b0 || busy !== 1'b0 || cfg_bus.cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_run: f=%0d w=%0d en=%0b busy=%0b ready=%0b want 0 0 0 0 1",
                  f_step, wave_select, phase_en, busy, cfg_bus.cfg_ready);
      end
      start = 1'b1;
      cyc();
      start = 1'b0;
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL rst_cfg_lost: busy=%0b want 0", busy);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 10; it++) begin
         int s, e;
         s = $urandom_range(0, 255);
         e = s + $urandom_range(0, 40);
         if (e > 255) e = 255;
         run_sweep(s, e, $urandom_range(1, 30), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(1, 3), 1, -1, 1'b0);
      end
   endtask

   initial begin
      rst = 1'b0; tick = 1'b0; start = 1'b0; abort = 1'b0;
      cfg_bus.cfg_valid = 1'b0;
      cfg_bus.cfg_start = '0;
      cfg_bus.cfg_stop  = '0;
      cfg_bus.cfg_inc   = '0;
      cfg_bus.cfg_dwell = '0;
      cfg_bus.cfg_wave  = '0;
      cfg_bus.cfg_loops = '0;
      test_reset();
      test_bad_cfg();
      run_sweep(10, 40, 10, 2, 1, 1, 0, -1, 1'b0);      // basic sweep
      run_sweep(200, 255, 100, 0, 3, 2, 0, -1, 1'b0);   // no wrap past top
      run_sweep(10, 40, 10, 2, 1, 1, 0, 6, 1'b1);       // abort at f_step=30, start held
      run_sweep(10, 30, 10, 0, 2, 1, 1, -1, 1'b0);      // up/down under pingpong
      run_sweep(77, 77, 5, 1, 0, 3, 1, -1, 1'b0);       // single point
      build_seq(5, 25, 4, 1, 3);
      run_sweep(5, 25, 4, 1, 0, 0, 1, exp_q.size() - 1, 1'b0); // infinite loops
      test_armed_replace();
      test_rst_mid_run();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
